// File: rtl/cbb_adder_tree.sv
// cbb_adder_tree
// Reduces one row of Contiguous Block Buffers to a single output row.
// Adjacent CBBs are summed pairwise, one tree level per clock, and each
// partial sum is written back into the lower CBB of the pair. Diagonal
// rows skip the reduction and deliver CBB0 exactly as it was loaded.
// The final row leaves over a valid/ready handshake from registered outputs.

module cbb_adder_tree #(
    parameter int NUM_CBB = 4,
    parameter int LANES   = 4,
    parameter int DW      = 8,
    parameter int OW      = DW + $clog2(NUM_CBB),
    parameter int RW      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    // input side
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_diag,
    input  logic [NUM_CBB-1:0]          in_cbb_mask,
    input  logic [NUM_CBB*LANES*DW-1:0] in_data,
    input  logic [RW-1:0]               in_row,
    // output side
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*OW-1:0]         out_data,
    // status
    output logic [RW-1:0]               out_row,
    output logic                        busy,
    output logic [15:0]                 rows_done
);

    // Number of tree levels, and the width of the counter that walks them.
    localparam int L   = $clog2(NUM_CBB);
    localparam int LVW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_reg;
    logic [LVW-1:0]        lvl_reg;
    logic [RW-1:0]         row_reg;
    logic                  out_valid_reg;
    logic [LANES*OW-1:0]   out_data_reg;
    logic [RW-1:0]         out_row_reg;
    logic [15:0]           rows_done_reg;

    // CBB storage, one signed OW-bit accumulator per lane.
    logic signed [OW-1:0]  cbb_reg    [NUM_CBB][LANES];

    // Value each CBB lane takes when a new row is accepted.
    logic signed [OW-1:0]  load_next  [NUM_CBB][LANES];

    // Candidate result of every tree level for every CBB lane.
    logic signed [OW-1:0]  level_sum  [NUM_CBB][LANES][L];

    // Value each CBB lane takes at the current level.
    logic signed [OW-1:0]  reduce_next[NUM_CBB][LANES];

    // CBB0 flattened into output lane order: as stored, and after this level.
    logic [LANES*OW-1:0]   cbb0_flat;
    logic [LANES*OW-1:0]   cbb0_reduced_flat;

    logic                  accept;
    logic                  last_level;
    logic                  out_fire;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign last_level = (lvl_reg == LVW'(L - 1));
    assign out_fire   = (state_reg == DONE) && out_valid_reg && out_ready;

    generate
        for (genvar gi = 0; gi < NUM_CBB; gi++) begin : g_cbb
            for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
                // Masked-off CBBs load as zero so they add nothing to the sum.
                assign load_next[gi][gl] = in_cbb_mask[gi]
                    ? {{(OW-DW){in_data[(gi*LANES+gl)*DW + DW - 1]}},
                       in_data[(gi*LANES+gl)*DW +: DW]}
                    : '0;

                for (genvar gj = 0; gj < L; gj++) begin : g_level
                    // At level gj the stride is 2^gj; only CBBs on a 2*stride
                    // boundary accumulate, every other CBB keeps its value.
                    if ((gi % (2 << gj)) == 0) begin : g_add
                        assign level_sum[gi][gl][gj] =
                            cbb_reg[gi][gl] + cbb_reg[gi + (1 << gj)][gl];
                    end else begin : g_hold
                        assign level_sum[gi][gl][gj] = cbb_reg[gi][gl];
                    end
                end

                assign reduce_next[gi][gl] = level_sum[gi][gl][lvl_reg];
            end
        end

        for (genvar gi = 0; gi < LANES; gi++) begin : g_out_lane
            assign cbb0_flat[gi*OW +: OW]         = cbb_reg[0][gi];
            assign cbb0_reduced_flat[gi*OW +: OW] = reduce_next[0][gi];
        end
    endgenerate

    // CBB datapath: load a new row on accept, fold one tree level per REDUCE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CBB; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    cbb_reg[k][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_CBB; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    cbb_reg[k][j] <= load_next[k][j];
                end
            end
        end else if (state_reg == REDUCE) begin
            for (int k = 0; k < NUM_CBB; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    cbb_reg[k][j] <= reduce_next[k][j];
                end
            end
        end
    end

    // Control FSM with registered output row, valid and delivered-row count.
    // A reduced row loads the output register on the edge of its last level;
    // a diagonal row spends its first DONE cycle staging CBB0 into it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            lvl_reg       <= '0;
            row_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_row_reg   <= '0;
            rows_done_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        row_reg   <= in_row;
                        lvl_reg   <= '0;
                        state_reg <= in_diag ? DONE : REDUCE;
                    end
                end

                REDUCE: begin
                    lvl_reg <= lvl_reg + 1'b1;
                    if (last_level) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= cbb0_reduced_flat;
                        out_row_reg   <= row_reg;
                    end
                end

                DONE: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= cbb0_flat;
                        out_row_reg   <= row_reg;
                    end else if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= '0;
                        rows_done_reg <= rows_done_reg + 16'd1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_row   = out_row_reg;
    assign rows_done = rows_done_reg;

endmodule
